// File: rtl/spi_byte_engine.sv
// spi_byte_engine: byte-wide SPI mode-0 master shift engine.
// Drives SCLK/MOSI, samples MISO, returns the last received byte and stalls the
// CPU (wait_n) when a new access arrives while a byte is still shifting.
// Build option: define SPI_LSB_FIRST_EN to shift LSB first on MOSI and MISO.
module spi_byte_engine #(
  parameter int unsigned DIV_HALF = 2,
  parameter logic [7:0]  IDLE_TX  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enviar_dato,
  input  logic       recibir_dato,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic       wait_n,
  output logic       spi_clk,
  output logic       spi_di,
  input  logic       spi_do,
  output logic       busy
);

  localparam int unsigned     DivW    = $clog2(DIV_HALF + 1);
  localparam logic [DivW-1:0] DivLoad = DivW'(DIV_HALF - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic            pend_q, pend_d;
  logic            wr_prev_q, rd_prev_q;
  logic            spi_clk_q, spi_clk_d;
  logic            spi_di_q, spi_di_d;
  logic            busy_q, busy_d;
  logic            wait_n_q, wait_n_d;

  logic            wr_start, rd_start, start;
  logic [7:0]      start_data;
  logic            launch;
  logic [7:0]      launch_data;

`ifdef SPI_LSB_FIRST_EN
  function automatic logic tx_bit(input logic [7:0] b);
    return b[0];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {1'b1, b[7:1]};
  endfunction
  // First received bit ends up in bit 0 after eight pushes.
  function automatic logic [7:0] rx_push(input logic [7:0] r, input logic s);
    return {s, r[7:1]};
  endfunction
`else
  function automatic logic tx_bit(input logic [7:0] b);
    return b[7];
  endfunction
  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {b[6:0], 1'b1};
  endfunction
  function automatic logic [7:0] rx_push(input logic [7:0] r, input logic s);
    return {r[6:0], s};
  endfunction
`endif

  // Level strobes become single-cycle starts; a write beats a simultaneous read.
  assign wr_start   = enviar_dato & ~wr_prev_q;
  assign rd_start   = recibir_dato & ~rd_prev_q;
  assign start      = wr_start | rd_start;
  assign start_data = wr_start ? din : IDLE_TX;

  // Next-state logic for the shift FSM, divider, shift registers and handshake.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dout_d      = dout_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    spi_clk_d   = spi_clk_q;
    spi_di_d    = spi_di_q;
    busy_d      = busy_q;
    wait_n_d    = wait_n_q;
    launch      = 1'b0;
    launch_data = start_data;

    // Mid-byte access: park it and stall the CPU until the current byte ends.
    if ((state_q == StLow || state_q == StHigh) && start && !pend_q) begin
      pend_d      = 1'b1;
      pend_data_d = start_data;
      wait_n_d    = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) launch = 1'b1;
      end
      StLow: begin
        if (div_q == '0) begin
          state_d   = StHigh;
          spi_clk_d = 1'b1;
          rx_d      = rx_push(rx_q, spi_do);
          div_d     = DivLoad;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StHigh: begin
        if (div_q == '0) begin
          spi_clk_d = 1'b0;
          div_d     = DivLoad;
          bit_d     = bit_q + 3'd1;
          if (bit_q != 3'd7) begin
            state_d  = StLow;
            tx_d     = tx_shift(tx_q);
            spi_di_d = tx_bit(tx_shift(tx_q));
          end else begin
            // Byte complete; release the stall so a waiting read sees the new dout.
            state_d  = StDone;
            dout_d   = rx_q;
            busy_d   = 1'b0;
            spi_di_d = 1'b1;
            wait_n_d = 1'b1;
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      StDone: begin
        if (pend_q) begin
          launch      = 1'b1;
          launch_data = pend_data_q;
          pend_d      = 1'b0;
        end else if (start) begin
          launch = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d   = StLow;
      tx_d      = launch_data;
      spi_di_d  = tx_bit(launch_data);
      busy_d    = 1'b1;
      div_d     = DivLoad;
      bit_d     = 3'd0;
      spi_clk_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_q       <= 3'd0;
      tx_q        <= 8'hFF;
      rx_q        <= 8'hFF;
      dout_q      <= 8'hFF;
      pend_q      <= 1'b0;
      pend_data_q <= 8'hFF;
      wr_prev_q   <= 1'b0;
      rd_prev_q   <= 1'b0;
      spi_clk_q   <= 1'b0;
      spi_di_q    <= 1'b1;
      busy_q      <= 1'b0;
      wait_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dout_q      <= dout_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      wr_prev_q   <= enviar_dato;
      rd_prev_q   <= recibir_dato;
      spi_clk_q   <= spi_clk_d;
      spi_di_q    <= spi_di_d;
      busy_q      <= busy_d;
      wait_n_q    <= wait_n_d;
    end
  end

  assign dout    = dout_q;
  assign oe_n    = ~recibir_dato;
  assign wait_n  = wait_n_q;
  assign spi_clk = spi_clk_q;
  assign spi_di  = spi_di_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: scoreboard bench for spi_byte_engine with DIV_HALF=2.
// Expected received bytes are queued when a transfer is launched and popped when
// busy falls; MOSI bytes are reassembled from spi_di at each rising SCLK.
module tb_spi_byte_engine;

  localparam int unsigned DivHalf = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enviar_dato;
  logic       recibir_dato;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;
  logic       wait_n;
  logic       spi_clk;
  logic       spi_di;
  logic       spi_do;
  logic       busy;

  int         checks = 0;
  int         failures = 0;

  logic [7:0] sb[$];
  logic [7:0] cur_dout;
  logic       busy_prev;

  logic [7:0] mosi_q[$];
  logic [7:0] mosi_sh = 8'h00;
  int         mosi_cnt = 0;
  int         rises = 0;
  int         falls = 0;
  int         falls_base = 0;
  logic       miso_loop;
  logic [7:0] pat;

  always #5 clk = ~clk;

  spi_byte_engine #(
    .DIV_HALF(DivHalf),
    .IDLE_TX (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enviar_dato (enviar_dato),
    .recibir_dato(recibir_dato),
    .din         (din),
    .dout        (dout),
    .oe_n        (oe_n),
    .wait_n      (wait_n),
    .spi_clk     (spi_clk),
    .spi_di      (spi_di),
    .spi_do      (spi_do),
    .busy        (busy)
  );

  // MISO slave model: bit k of the pattern is presented before the k-th rising SCLK.
  function automatic logic miso_bit(input logic [7:0] p, input logic [2:0] k);
`ifdef SPI_LSB_FIRST_EN
    return p[k];
`else
    return p[3'd7 - k];
`endif
  endfunction

  assign spi_do = miso_loop ? spi_di : miso_bit(pat, 3'((falls - falls_base) % 8));

  // Reassemble MOSI bytes at rising SCLK.
  always @(posedge spi_clk or posedge rst) begin
    if (rst) begin
      mosi_cnt = 0;
    end else begin
      rises++;
`ifdef SPI_LSB_FIRST_EN
      mosi_sh = {spi_di, mosi_sh[7:1]};
`else
      mosi_sh = {mosi_sh[6:0], spi_di};
`endif
      mosi_cnt++;
      if (mosi_cnt == 8) begin
        mosi_q.push_back(mosi_sh);
        mosi_cnt = 0;
      end
    end
  end

  always @(negedge spi_clk) falls++;

  // Advance one cycle; pop the scoreboard when busy falls and return expected dout.
  task automatic step(output logic fell, output logic [7:0] exp);
    @(negedge clk);
    fell = busy_prev && !busy;
    exp  = cur_dout;
    if (fell) begin
      if (sb.size() > 0) begin
        exp      = sb.pop_front();
        cur_dout = exp;
      end else begin
        exp = 8'hxx;
      end
    end
    busy_prev = busy;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    enviar_dato  = 1'b0;
    recibir_dato = 1'b0;
    din          = 8'h00;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    sb.delete();
    cur_dout  = 8'hFF;
    busy_prev = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int rb;
    do_reset();
    checks++; if (dout !== 8'hFF) begin failures++; $display("FAIL reset_dout got=%h want=ff", dout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b want=0", spi_clk); end
    checks++; if (spi_di !== 1'b1) begin failures++; $display("FAIL reset_mosi got=%b want=1", spi_di); end
    checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL reset_wait_n got=%b want=1", wait_n); end
    checks++; if (oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe_n got=%b want=1", oe_n); end
    // Launch a transfer of 0x00 and abort it with reset in cycle N+10.
    miso_loop = 1'b1;
    din = 8'h00;
    enviar_dato = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b want=1", busy); end
    checks++; if (spi_di !== 1'b0) begin failures++; $display("FAIL abort_mosi_before got=%b want=0", spi_di); end
    #2 rst = 1'b1;
    #1;
    checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b want=0", spi_clk); end
    checks++; if (spi_di !== 1'b1) begin failures++; $display("FAIL abort_mosi got=%b want=1", spi_di); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
    checks++; if (dout !== 8'hFF) begin failures++; $display("FAIL abort_dout got=%h want=ff", dout); end
    rb = rises;
    enviar_dato = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    busy_prev = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (rises != rb) begin failures++; $display("FAIL abort_no_edges got=%0d want=0", rises - rb); end
    checks++; if (dout !== 8'hFF) begin failures++; $display("FAIL abort_dout_after got=%h want=ff", dout); end
  endtask

  task automatic test_write();
    int mb, rb;
    logic fell, eb, ec;
    logic [7:0] exp;
    miso_loop = 1'b1;
    mb = mosi_q.size();
    rb = rises;
    @(negedge clk);
    din = 8'hA5;
    enviar_dato = 1'b1;
    sb.push_back(8'hA5);
    for (int k = 1; k <= 36; k++) begin
      step(fell, exp);
      eb = (k <= 32);
      ec = (k <= 32) && (((k - 1) % 4) >= 2);
      checks++; if (busy !== eb) begin failures++; $display("FAIL wr_busy k=%0d got=%b want=%b", k, busy, eb); end
      checks++; if (spi_clk !== ec) begin failures++; $display("FAIL wr_sclk k=%0d got=%b want=%b", k, spi_clk, ec); end
      checks++; if (dout !== exp) begin failures++; $display("FAIL wr_dout k=%0d got=%h want=%h", k, dout, exp); end
      if (k == 1) begin
        checks++; if (spi_di !== 1'b1) begin failures++; $display("FAIL wr_first_bit got=%b want=1", spi_di); end
      end
      if (k == 2) enviar_dato = 1'b0;
    end
    checks++; if (rises - rb != 8) begin failures++; $display("FAIL wr_rises got=%0d want=8", rises - rb); end
    checks++;
    if (mosi_q.size() <= mb || mosi_q[mb] !== 8'hA5) begin
      failures++; $display("FAIL wr_mosi got=%h want=a5", (mosi_q.size() > mb) ? mosi_q[mb] : 8'hxx);
    end
  endtask

  task automatic test_read();
    int mb, rb;
    logic fell;
    logic [7:0] exp;
    do_reset();
    miso_loop = 1'b0;
    pat = 8'h3C;
    falls_base = falls;
    mb = mosi_q.size();
    rb = rises;
    recibir_dato = 1'b1;
    sb.push_back(8'h3C);
    #1;
    checks++; if (oe_n !== 1'b0) begin failures++; $display("FAIL rd_oe_n got=%b want=0", oe_n); end
    checks++; if (dout !== 8'hFF) begin failures++; $display("FAIL rd_old_dout got=%h want=ff", dout); end
    for (int k = 1; k <= 36; k++) begin
      step(fell, exp);
      checks++; if (dout !== exp) begin failures++; $display("FAIL rd_dout k=%0d got=%h want=%h", k, dout, exp); end
      checks++; if (oe_n !== !recibir_dato) begin failures++; $display("FAIL rd_oe k=%0d got=%b want=%b", k, oe_n, !recibir_dato); end
      if (k == 4) recibir_dato = 1'b0;
    end
    checks++; if (dout !== 8'h3C) begin failures++; $display("FAIL rd_final got=%h want=3c", dout); end
    checks++; if (rises - rb != 8) begin failures++; $display("FAIL rd_rises got=%0d want=8", rises - rb); end
    checks++;
    if (mosi_q.size() <= mb || mosi_q[mb] !== 8'hFF) begin
      failures++; $display("FAIL rd_mosi got=%h want=ff", (mosi_q.size() > mb) ? mosi_q[mb] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int mb, rb;
    logic fell, ew, eb;
    logic [7:0] exp;
    miso_loop = 1'b1;
    mb = mosi_q.size();
    rb = rises;
    @(negedge clk);
    din = 8'h12;
    enviar_dato = 1'b1;
    sb.push_back(8'h12);
    for (int k = 1; k <= 68; k++) begin
      step(fell, exp);
      ew = !(k >= 6 && k <= 32);
      eb = (k <= 32) || (k >= 34 && k <= 65);
      checks++; if (wait_n !== ew) begin failures++; $display("FAIL b2b_wait_n k=%0d got=%b want=%b", k, wait_n, ew); end
      checks++; if (busy !== eb) begin failures++; $display("FAIL b2b_busy k=%0d got=%b want=%b", k, busy, eb); end
      checks++; if (dout !== exp) begin failures++; $display("FAIL b2b_dout k=%0d got=%h want=%h", k, dout, exp); end
      if (k == 2) enviar_dato = 1'b0;
      if (k == 5) begin
        recibir_dato = 1'b1;
        sb.push_back(8'hFF);
      end
      if (k == 34) recibir_dato = 1'b0;
    end
    checks++; if (rises - rb != 16) begin failures++; $display("FAIL b2b_rises got=%0d want=16", rises - rb); end
    checks++;
    if (mosi_q.size() < mb + 2 || mosi_q[mb] !== 8'h12 || mosi_q[mb+1] !== 8'hFF) begin
      failures++; $display("FAIL b2b_mosi got_count=%0d want=2 bytes 12 ff", mosi_q.size() - mb);
    end
  endtask

  task automatic test_level_hold();
    int rb, nfall;
    logic fell;
    logic [7:0] exp;
    miso_loop = 1'b1;
    rb = rises;
    nfall = 0;
    @(negedge clk);
    din = 8'hC3;
    enviar_dato = 1'b1;
    sb.push_back(8'hC3);
    for (int k = 1; k <= 110; k++) begin
      step(fell, exp);
      if (fell) nfall++;
      checks++; if (dout !== exp) begin failures++; $display("FAIL hold_dout k=%0d got=%h want=%h", k, dout, exp); end
      if (k == 100) enviar_dato = 1'b0;
    end
    checks++; if (rises - rb != 8) begin failures++; $display("FAIL hold_rises got=%0d want=8", rises - rb); end
    checks++; if (nfall != 1) begin failures++; $display("FAIL hold_transfers got=%0d want=1", nfall); end
    checks++; if (dout !== 8'hC3) begin failures++; $display("FAIL hold_final got=%h want=c3", dout); end
  endtask

  task automatic test_simultaneous();
    int mb, rb;
    logic fell;
    logic [7:0] exp;
    miso_loop = 1'b1;
    mb = mosi_q.size();
    rb = rises;
    @(negedge clk);
    din = 8'h5A;
    enviar_dato = 1'b1;
    recibir_dato = 1'b1;
    sb.push_back(8'h5A);
    #1;
    checks++; if (oe_n !== 1'b0) begin failures++; $display("FAIL sim_oe_n got=%b want=0", oe_n); end
    checks++; if (dout !== 8'hC3) begin failures++; $display("FAIL sim_old_dout got=%h want=c3", dout); end
    for (int k = 1; k <= 40; k++) begin
      step(fell, exp);
      checks++; if (dout !== exp) begin failures++; $display("FAIL sim_dout k=%0d got=%h want=%h", k, dout, exp); end
      checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL sim_wait_n k=%0d got=%b want=1", k, wait_n); end
      if (k == 3) begin
        enviar_dato = 1'b0;
        recibir_dato = 1'b0;
      end
    end
    checks++; if (rises - rb != 8) begin failures++; $display("FAIL sim_rises got=%0d want=8", rises - rb); end
    checks++;
    if (mosi_q.size() <= mb || mosi_q[mb] !== 8'h5A) begin
      failures++; $display("FAIL sim_mosi got=%h want=5a", (mosi_q.size() > mb) ? mosi_q[mb] : 8'hxx);
    end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
  endtask

  initial begin
    rst          = 1'b1;
    enviar_dato  = 1'b0;
    recibir_dato = 1'b0;
    din          = 8'h00;
    miso_loop    = 1'b1;
    pat          = 8'h00;
    cur_dout     = 8'hFF;
    busy_prev    = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_level_hold();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_byte_engine.md
Name: spi_byte_engine

Overview:
Byte-wide SPI master shift engine. It sits directly downstream of the flash/SD chip-select and port-decode block, which supplies level-type write/read strobes and the CPU data byte. The engine drives the shared SCLK/MOSI lines and samples MISO in SPI mode 0, MSB first. It returns the last received byte to the CPU bus and stalls the CPU when a new access arrives mid-transfer.

Parameters:
DIV_HALF, 2, clk cycles per SPI half-period (>=1); one byte takes 16*DIV_HALF clk cycles.
IDLE_TX, 8'hFF, byte shifted out when a transfer is launched by a read strobe.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
enviar_dato  input  1  write strobe (level, held for the whole CPU I/O cycle)
recibir_dato  input  1  read strobe (level)
din  input  8  byte to transmit, sampled on the write-strobe rising edge
dout  output  8  last completed received byte
oe_n  output  1  low while recibir_dato is high (dout valid for the bus)
wait_n  output  1  low = stall CPU
spi_clk  output  1  SCLK, idle low
spi_di  output  1  MOSI, idle high
spi_do  input  1  MISO
busy  output  1  high while a byte is shifting

Behaviour:
- Reset (async, immediate): state IDLE; spi_clk=0, spi_di=1, dout=8'hFF, busy=0, wait_n=1, pending cleared, strobe edge registers cleared. Reset asserted mid-transfer aborts it; no partial byte reaches dout.
- Edge detect: registered copies of the strobes. wr_start = enviar_dato & ~prev. rd_start = recibir_dato & ~prev. Level-held strobes launch exactly one transfer.
- oe_n = ~recibir_dato (combinational). dout is registered and changes only at transfer completion.
- Launch data: wr_start loads din into the tx shift register. rd_start loads IDLE_TX. A read returns the byte from the previous transfer, then launches a new one (read-ahead).
- Both edges in the same cycle: the write wins (din is sent). oe_n still follows recibir_dato, and dout shows the previous byte.
- FSM: IDLE -> LOW -> HIGH -> LOW ... -> DONE -> IDLE.
  - IDLE: on start (cycle N), tx loaded and spi_di = tx[7] at N+1; busy=1 from N+1.
  - LOW: spi_clk=0 for DIV_HALF cycles, then -> HIGH.
  - HIGH: spi_clk=1 for DIV_HALF cycles. spi_do is sampled into the rx shift register on the clk edge where spi_clk rises. On leaving HIGH: if bit count < 7, shift tx, present the next bit on spi_di, increment the count, -> LOW; else -> DONE.
  - DONE: one cycle; spi_clk=0, dout<=rx, busy=0, spi_di=1, -> IDLE (or launch pending).
- First SCLK rise at N+1+DIV_HALF. dout updates at N+1+16*DIV_HALF.
- Pending/stall: a start edge while busy latches a one-deep pending request (din or IDLE_TX captured at the edge) and drives wait_n=0 from the next cycle.
  - The pending request launches from DONE with no IDLE gap.
  - wait_n returns to 1 in the cycle busy drops for the previous byte, so the stalled read sees the updated dout.
  - A further edge while pending is already set is ignored. It cannot occur, since the CPU is stalled.
- Bit counter is 3 bits and wraps 7->0 at DONE. The divider counter is ceil(log2(DIV_HALF+1)) bits and reloads at each phase change.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: bits are shifted LSB first on both MOSI and MISO; rx assembles from bit 7 downward, so dout holds the byte in natural order.
- Undefined: MSB first, as described above.
- Timing, handshake and reset behaviour are identical in both builds.

Test Plan:
- Reset: assert rst mid-transfer at cycle 10 -> spi_clk=0, spi_di=1, busy=0, dout=8'hFF immediately, with no further SCLK edges.
- Write 8'hA5, DIV_HALF=2, spi_do looping spi_di -> MOSI bits 1,0,1,0,0,1,0,1 on rising SCLK. Exactly 8 rises, first at N+3. busy is high for 32 cycles. dout=8'hA5 at N+33.
- Read with spi_do tied to pattern 8'h3C -> oe_n low during the strobe; dout shows the old byte (8'hFF after reset). MOSI sends 8'hFF. dout=8'h3C after completion.
- Back-to-back: write 8'h12 then read edge at N+5 -> wait_n=0 from N+6 until busy falls. Second transfer starts from DONE with no idle cycle. The read-ahead then sends 8'hFF.
- Level hold: enviar_dato held high for 100 cycles -> exactly one transfer (8 SCLK rises).
- Simultaneous rising edges of enviar_dato and recibir_dato with din=8'h5A -> MOSI carries 8'h5A; oe_n is low; dout is unchanged until DONE.
